// File: rtl/clock_pkg.sv
// Shared types for the clock board display/mode controller.
// Contents:
//   mode_t    - display mode selected by the mode button (3-bit code)
//   ring_t    - ring overlay state (quiet, alarm ring, countdown ring)
//   bcd4_t    - four packed BCD digits as fed to the scanner
//   MODE_LAST - last mode in the cycle, after which the mode wraps
//   nextMode  - mode that follows a given mode on a button press
package clock_pkg;

   typedef enum logic [2:0] {
      TIME_HM   = 3'd0,
      TIME_MS   = 3'd1,
      ALARM_SET = 3'd2,
      COUNTDOWN = 3'd3,
      STOPWATCH = 3'd4
   } mode_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RING_AL = 2'd1,
      RING_CD = 2'd2
   } ring_t;

   typedef logic [15:0] bcd4_t;

   localparam mode_t MODE_LAST = STOPWATCH;

   // Modes are numbered consecutively, so advancing is an increment
   // with a wrap back to the first mode after the last one.
   function automatic mode_t nextMode(input mode_t m);
      if (m == MODE_LAST) begin
         return TIME_HM;
      end
      return mode_t'(m + 3'd1);
   endfunction

endpackage

// File: rtl/disp_mode_ctrl_if.sv
// Bundle of signals between the counter datapath/buttons (master side)
// and the display mode controller (slave side).
// Inputs to the controller:
//   tick_1hz    - one-cycle pulse once per second
//   btn_mode    - raw asynchronous mode button
//   btn_ack     - raw asynchronous acknowledge button
//   alarm_match - level, high while time equals an armed alarm
//   cd_zero     - one-cycle pulse when the countdown reaches zero
//   time_hm, time_ms, alarm_hm, cd_val, sw_val - BCD display sources
// Outputs from the controller:
//   disp_data   - BCD digits to the scanner
//   disp_blank  - per-digit blank, 1 = digit off
//   mode        - current display mode
//   edit_time   - set buttons drive the time counters
//   edit_alarm  - set buttons drive the alarm counters
//   buzz        - high while a ring is active
//   ring_src    - source of the active ring, 0 = alarm, 1 = countdown
interface disp_mode_ctrl_if;

   logic             tick_1hz;
   logic             btn_mode;
   logic             btn_ack;
   logic             alarm_match;
   logic             cd_zero;
   clock_pkg::bcd4_t time_hm;
   clock_pkg::bcd4_t time_ms;
   clock_pkg::bcd4_t alarm_hm;
   clock_pkg::bcd4_t cd_val;
   clock_pkg::bcd4_t sw_val;

   clock_pkg::bcd4_t disp_data;
   logic [3:0]       disp_blank;
   clock_pkg::mode_t mode;
   logic             edit_time;
   logic             edit_alarm;
   logic             buzz;
   logic             ring_src;

   modport master (
      output tick_1hz, btn_mode, btn_ack, alarm_match, cd_zero,
      output time_hm, time_ms, alarm_hm, cd_val, sw_val,
      input  disp_data, disp_blank, mode, edit_time, edit_alarm, buzz, ring_src
   );

   modport slave (
      input  tick_1hz, btn_mode, btn_ack, alarm_match, cd_zero,
      input  time_hm, time_ms, alarm_hm, cd_val, sw_val,
      output disp_data, disp_blank, mode, edit_time, edit_alarm, buzz, ring_src
   );

endinterface

// File: rtl/btn_debounce.sv
// Push-button conditioner: two-flop synchronizer followed by a
// stable-count debouncer that emits a one-cycle press pulse when a
// 0->1 transition has been stable for DEB_CYCLES cycles.
// Ports:
//   clk     - system clock
//   clr     - synchronous active-high reset
//   btn_i   - raw asynchronous button level
//   press_o - one-cycle pulse on an accepted press
module btn_debounce #(
   parameter int DEB_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic clr,
   input  logic btn_i,
   output logic press_o
);

   localparam int CW = $clog2(DEB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          press_q;
   logic [CW-1:0] cnt_q;

   // The accepted level comes out of reset as "pressed": a button held
   // through reset is then seen as already down and must be released
   // (which produces no pulse) before a new press can be accepted.
   // Any disagreement between the synchronized input and the accepted
   // level is counted; a bounce back to the accepted level restarts it.
   always_ff @(posedge clk) begin
      if (clr) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b1;
         press_q <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
         press_q <= 1'b0;
         if (sync2_q == level_q) begin
            cnt_q <= '0;
         end else if (cnt_q == CNT_LAST) begin
            level_q <= sync2_q;
            press_q <= sync2_q;
            cnt_q   <= '0;
         end else begin
            cnt_q <= cnt_q + 1'b1;
         end
      end
   end

   assign press_o = press_q;

endmodule

// File: rtl/disp_mode_ctrl.sv
// Display mode controller and arbiter for the shared 4-digit scanner.
// Cycles the display between time, alarm setpoint, countdown and
// stopwatch on mode presses; alarm and countdown-expiry events take
// over the display with a blinking ring overlay until acknowledged or
// timed out; steers the set buttons to the time or alarm counters.
// Ports:
//   clk - system clock (single clock domain)
//   clr - synchronous active-high reset
//   bus - slave side of disp_mode_ctrl_if (sources, buttons, events
//         in; scanner data, blanking, mode, edit routing, buzz out)
module disp_mode_ctrl
   import clock_pkg::*;
#(
   parameter int DEB_CYCLES = 1_000_000,
   parameter int RING_SECS  = 30
) (
   input logic             clk,
   input logic             clr,
   disp_mode_ctrl_if.slave bus
);

   localparam int RCW = $clog2(RING_SECS + 1);
   localparam logic [RCW-1:0] RING_LAST = RCW'(RING_SECS - 1);

   logic           modePress;
   logic           ackPress;
   logic           alarmEdge;
   logic           ringEnd;

   mode_t          mode_q,      mode_d;
   ring_t          ring_q,      ring_d;
   logic [RCW-1:0] ringCnt_q,   ringCnt_d;
   logic           blink_q,     blink_d;
   logic           cdPend_q,    cdPend_d;
   logic           alPend_q,    alPend_d;
   logic           alarmPrev_q;

   bcd4_t          dispData_q,  dispData_d;
   logic [3:0]     dispBlank_q, dispBlank_d;
   logic           buzz_q,      buzz_d;
   logic           ringSrc_q,   ringSrc_d;
   logic           editTime_q,  editTime_d;
   logic           editAlarm_q, editAlarm_d;

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debMode (
      .clk     (clk),
      .clr     (clr),
      .btn_i   (bus.btn_mode),
      .press_o (modePress)
   );

   btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_debAck (
      .clk     (clk),
      .clr     (clr),
      .btn_i   (bus.btn_ack),
      .press_o (ackPress)
   );

   // An alarm only rings on the rising edge of the match level, and not
   // while the user is editing the alarm setpoint itself.
   assign alarmEdge = bus.alarm_match & ~alarmPrev_q & (mode_q != ALARM_SET);

   // State and output registers.
   always_ff @(posedge clk) begin
      if (clr) begin
         mode_q      <= TIME_HM;
         ring_q      <= IDLE;
         ringCnt_q   <= '0;
         blink_q     <= 1'b0;
         cdPend_q    <= 1'b0;
         alPend_q    <= 1'b0;
         alarmPrev_q <= 1'b0;
         dispData_q  <= '0;
         dispBlank_q <= 4'b0000;
         buzz_q      <= 1'b0;
         ringSrc_q   <= 1'b0;
         editTime_q  <= 1'b1;
         editAlarm_q <= 1'b0;
      end else begin
         mode_q      <= mode_d;
         ring_q      <= ring_d;
         ringCnt_q   <= ringCnt_d;
         blink_q     <= blink_d;
         cdPend_q    <= cdPend_d;
         alPend_q    <= alPend_d;
         alarmPrev_q <= bus.alarm_match;
         dispData_q  <= dispData_d;
         dispBlank_q <= dispBlank_d;
         buzz_q      <= buzz_d;
         ringSrc_q   <= ringSrc_d;
         editTime_q  <= editTime_d;
         editAlarm_q <= editAlarm_d;
      end
   end

   // Next-state logic for the mode and ring machines. A mode press only
   // advances the mode when nothing is ringing; during a ring it is
   // consumed as an acknowledge. The other source's event during a ring
   // is remembered in its pend flag and taken up when the ring ends,
   // with a fresh count and blink phase. The entry cycle resets the
   // count, so a tick coinciding with entry is not counted.
   always_comb begin
      mode_d    = mode_q;
      ring_d    = ring_q;
      ringCnt_d = ringCnt_q;
      blink_d   = blink_q;
      cdPend_d  = cdPend_q;
      alPend_d  = alPend_q;
      ringEnd   = 1'b0;
      case (ring_q)
         IDLE: begin
            ringCnt_d = '0;
            blink_d   = 1'b0;
            if (modePress) begin
               mode_d = nextMode(mode_q);
            end
            if (alarmEdge) begin
               ring_d   = RING_AL;
               cdPend_d = bus.cd_zero;
            end else if (bus.cd_zero) begin
               ring_d = RING_CD;
            end
         end
         RING_AL, RING_CD: begin
            if (ring_q == RING_AL && bus.cd_zero) begin
               cdPend_d = 1'b1;
            end
            if (ring_q == RING_CD && alarmEdge) begin
               alPend_d = 1'b1;
            end
            ringEnd = ackPress | modePress | (bus.tick_1hz & (ringCnt_q == RING_LAST));
            if (ringEnd) begin
               ringCnt_d = '0;
               blink_d   = 1'b0;
               if (ring_q == RING_AL && cdPend_d) begin
                  ring_d   = RING_CD;
                  cdPend_d = 1'b0;
               end else if (ring_q == RING_CD && alPend_d) begin
                  ring_d   = RING_AL;
                  alPend_d = 1'b0;
               end else begin
                  ring_d = IDLE;
               end
            end else if (bus.tick_1hz) begin
               ringCnt_d = ringCnt_q + 1'b1;
               blink_d   = ~blink_q;
            end
         end
         default: begin
            ring_d = IDLE;
         end
      endcase
   end

   // Output decode from the next state, so that every output is a flop
   // that reflects a press or event one cycle after it is seen.
   always_comb begin
      dispData_d = bus.time_hm;
      case (ring_d)
         RING_AL: dispData_d = bus.alarm_hm;
         RING_CD: dispData_d = bus.cd_val;
         default: begin
            case (mode_d)
               TIME_HM:   dispData_d = bus.time_hm;
               TIME_MS:   dispData_d = bus.time_ms;
               ALARM_SET: dispData_d = bus.alarm_hm;
               COUNTDOWN: dispData_d = bus.cd_val;
               STOPWATCH: dispData_d = bus.sw_val;
               default:   dispData_d = bus.time_hm;
            endcase
         end
      endcase
      dispBlank_d = (ring_d != IDLE) ? {4{blink_d}} : 4'b0000;
      buzz_d      = (ring_d != IDLE);
      ringSrc_d   = (ring_d == RING_CD);
      editTime_d  = (mode_d == TIME_HM) && (ring_d == IDLE);
      editAlarm_d = (mode_d == ALARM_SET) && (ring_d == IDLE);
   end

   assign bus.disp_data  = dispData_q;
   assign bus.disp_blank = dispBlank_q;
   assign bus.mode       = mode_q;
   assign bus.edit_time  = editTime_q;
   assign bus.edit_alarm = editAlarm_q;
   assign bus.buzz       = buzz_q;
   assign bus.ring_src   = ringSrc_q;

endmodule
